pipeline_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RISC-V core on the AXI bus.

---
 rtl/pipeline_stall_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: merges hazard stalls, AXI IM/DM waits and branch flushes.
// Optional STALL_PERF_EN adds saturating perf counters for frozen, hazard-stall and flush cycles.
module pipeline_stall_ctrl #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_stall_i,
    input  logic             branch_taken_i,
    input  logic             im_req_i,
    input  logic             im_done_i,
    input  logic             dm_req_i,
    input  logic             dm_done_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_write_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             hazard_mux_ctrl_o,
`ifdef STALL_PERF_EN
    output logic [CNT_W-1:0] perf_frz_cyc_o,
    output logic [CNT_W-1:0] perf_haz_cyc_o,
    output logic [CNT_W-1:0] perf_flush_cnt_o,
`endif
    output logic             stall_timeout_o
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic             im_out_q, im_out_d;
    logic             dm_out_q, dm_out_d;
    logic [CNT_W-1:0] frz_cnt_q, frz_cnt_d;
    logic             timeout_q, timeout_d;
    logic             freeze_s;
    logic             flush_case_s;
    logic             haz_case_s;

    // A done pulse releases the freeze in the same cycle because its data is already valid.
    assign freeze_s = (im_out_q & ~im_done_i) | (dm_out_q & ~dm_done_i)
                    | (im_req_i & ~im_done_i) | (dm_req_i & ~dm_done_i);
    assign flush_case_s = ~freeze_s & branch_taken_i;
    assign haz_case_s   = ~freeze_s & ~branch_taken_i & hazard_stall_i;

    // Next-state for outstanding bits and the freeze watchdog.
    always_comb begin
        im_out_d  = im_out_q ? ~im_done_i : (im_req_i & ~im_done_i);
        dm_out_d  = dm_out_q ? ~dm_done_i : (dm_req_i & ~dm_done_i);
        frz_cnt_d = {CNT_W{1'b0}};
        timeout_d = timeout_q;
        if (freeze_s) begin
            frz_cnt_d = sat_inc(frz_cnt_q);
            if (frz_cnt_q >= TO_LAST) begin
                timeout_d = 1'b1;
            end else begin
                timeout_d = timeout_q;
            end
        end else begin
            frz_cnt_d = {CNT_W{1'b0}};
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_out_q  <= 1'b0;
            dm_out_q  <= 1'b0;
            frz_cnt_q <= {CNT_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            im_out_q  <= im_out_d;
            dm_out_q  <= dm_out_d;
            frz_cnt_q <= frz_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Priority decode: reset, freeze, branch flush, hazard bubble, normal run.
    always_comb begin
        pc_write_o        = 1'b0;
        if_id_write_o     = 1'b0;
        id_ex_write_o     = 1'b0;
        ex_mem_write_o    = 1'b0;
        mem_wb_write_o    = 1'b0;
        if_id_flush_o     = 1'b0;
        id_ex_flush_o     = 1'b0;
        hazard_mux_ctrl_o = 1'b1;
        if (!rst_n || freeze_s) begin
            pc_write_o = 1'b0;
        end else if (branch_taken_i) begin
            {pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o, mem_wb_write_o} = 5'b11111;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (hazard_stall_i) begin
            {id_ex_write_o, ex_mem_write_o, mem_wb_write_o} = 3'b111;
            hazard_mux_ctrl_o = 1'b0;
        end else begin
            {pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o, mem_wb_write_o} = 5'b11111;
        end
    end

    assign stall_timeout_o = timeout_q;

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] perf_frz_q, perf_haz_q, perf_flush_q;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_frz_q   <= {CNT_W{1'b0}};
            perf_haz_q   <= {CNT_W{1'b0}};
            perf_flush_q <= {CNT_W{1'b0}};
        end else begin
            perf_frz_q   <= freeze_s     ? sat_inc(perf_frz_q)   : perf_frz_q;
            perf_haz_q   <= haz_case_s   ? sat_inc(perf_haz_q)   : perf_haz_q;
            perf_flush_q <= flush_case_s ? sat_inc(perf_flush_q) : perf_flush_q;
        end
    end

    assign perf_frz_cyc_o   = perf_frz_q;
    assign perf_haz_cyc_o   = perf_haz_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl; expected output vectors are queued when each step is
// driven and popped when the outputs are sampled mid-cycle.
module tb_pipeline_stall_ctrl;

    localparam int unsigned CNT_W = 32;
    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, hazard_mux}
    localparam logic [7:0] P_RUN   = 8'b11111_00_1;
    localparam logic [7:0] P_FRZ   = 8'b00000_00_1;
    localparam logic [7:0] P_FLUSH = 8'b11111_11_1;
    localparam logic [7:0] P_HAZ   = 8'b00111_00_0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hz = 1'b0, br = 1'b0, ir = 1'b0, id = 1'b0, dr = 1'b0, dd = 1'b0;
    logic pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, hmux, tmo;
`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] perf_frz, perf_haz, perf_flush;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_frz  = 0;
    int n_haz  = 0;
    int n_fl   = 0;
    logic [8:0] sb_q[$];

    pipeline_stall_ctrl #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .hazard_stall_i(hz), .branch_taken_i(br),
        .im_req_i(ir), .im_done_i(id), .dm_req_i(dr), .dm_done_i(dd),
        .pc_write_o(pc_w), .if_id_write_o(ifid_w), .id_ex_write_o(idex_w),
        .ex_mem_write_o(exmem_w), .mem_wb_write_o(memwb_w),
        .if_id_flush_o(ifid_f), .id_ex_flush_o(idex_f), .hazard_mux_ctrl_o(hmux),
`ifdef STALL_PERF_EN
        .perf_frz_cyc_o(perf_frz), .perf_haz_cyc_o(perf_haz), .perf_flush_cnt_o(perf_flush),
`endif
        .stall_timeout_o(tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One cycle: drive at negedge, queue the expectation, sample 2 time units later.
    task automatic step(input logic r, input logic [5:0] in_v, input logic [7:0] exp_p,
                        input logic exp_to, input string tag);
        logic [8:0] exp_v;
        logic [8:0] obs_v;
        @(negedge clk);
        rst_n = r;
        {hz, br, ir, id, dr, dd} = in_v;
        sb_q.push_back({exp_to, exp_p});
        #2;
        obs_v = {tmo, pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, hmux};
        if (sb_q.size() == 0) begin
            n_chk++;
            $error("FAIL %s observed=%0h expected=scoreboard-entry", tag, obs_v);
        end else begin
            exp_v = sb_q.pop_front();
            check(tag, {23'd0, obs_v}, {23'd0, exp_v});
        end
        if (r) begin
            if (exp_p == P_FRZ) n_frz++;
            else if (exp_p == P_HAZ) n_haz++;
            else if (exp_p == P_FLUSH) n_fl++;
        end
    endtask

    // input order: {hazard, branch, im_req, im_done, dm_req, dm_done}
    initial begin
        step(1'b0, 6'b000000, P_FRZ, 1'b0, "rst_idle");
        step(1'b0, 6'b011000, P_FRZ, 1'b0, "rst_br_imreq");
        step(1'b0, 6'b110000, P_FRZ, 1'b0, "rst_hz_br");
        // 1) reset release
        step(1'b1, 6'b000000, P_RUN, 1'b0, "run0");
        step(1'b1, 6'b000000, P_RUN, 1'b0, "run1");
        // 2) im_req cycle 0, im_done cycle 3
        step(1'b1, 6'b001000, P_FRZ, 1'b0, "im_c0");
        step(1'b1, 6'b000000, P_FRZ, 1'b0, "im_c1");
        step(1'b1, 6'b001000, P_FRZ, 1'b0, "im_c2_req_ignored");
        step(1'b1, 6'b000100, P_RUN, 1'b0, "im_c3_done");
        step(1'b1, 6'b000000, P_RUN, 1'b0, "im_c4");
        // 3) flush beats hazard, then plain hazard bubble
        step(1'b1, 6'b110000, P_FLUSH, 1'b0, "hz_br");
        step(1'b1, 6'b100000, P_HAZ, 1'b0, "hz_only");
        step(1'b1, 6'b000000, P_RUN, 1'b0, "after_hz");
        // freeze beats hazard; release with hazard pending gives a bubble
        step(1'b1, 6'b101000, P_FRZ, 1'b0, "hz_under_frz");
        step(1'b1, 6'b100100, P_HAZ, 1'b0, "hz_at_release");
        // 4) dm outstanding with held branch
        step(1'b1, 6'b010010, P_FRZ, 1'b0, "dm_br_c0");
        for (int i = 1; i < 4; i++) step(1'b1, 6'b010000, P_FRZ, 1'b0, "dm_br_held");
        step(1'b1, 6'b010001, P_FLUSH, 1'b0, "dm_br_c4_done");
        step(1'b1, 6'b000000, P_RUN, 1'b0, "after_dm");
        // both outstanding: im_done alone keeps dm freeze
        step(1'b1, 6'b001000, P_FRZ, 1'b0, "both_im");
        step(1'b1, 6'b000010, P_FRZ, 1'b0, "both_dm");
        step(1'b1, 6'b000100, P_FRZ, 1'b0, "both_im_done");
        step(1'b1, 6'b000001, P_RUN, 1'b0, "both_dm_done");
        // simultaneous completion
        step(1'b1, 6'b001010, P_FRZ, 1'b0, "sim_req");
        step(1'b1, 6'b000101, P_RUN, 1'b0, "sim_done");
        step(1'b1, 6'b000000, P_RUN, 1'b0, "sim_after");
        // 6) same-cycle req+done, stray dm_done, stray im_done
        step(1'b1, 6'b001100, P_RUN, 1'b0, "im_req_done");
        step(1'b1, 6'b000001, P_RUN, 1'b0, "stray_dm_done");
        step(1'b1, 6'b000100, P_RUN, 1'b0, "stray_im_done");
        step(1'b1, 6'b000000, P_RUN, 1'b0, "stray_after");
        // 5) watchdog with TIMEOUT=8
        step(1'b1, 6'b001000, P_FRZ, 1'b0, "wd_c0");
        for (int i = 1; i < 8; i++) step(1'b1, 6'b000000, P_FRZ, 1'b0, "wd_frozen");
        step(1'b1, 6'b000000, P_FRZ, 1'b1, "wd_timeout");
        step(1'b1, 6'b000100, P_RUN, 1'b1, "wd_release_sticky");
        step(1'b1, 6'b000000, P_RUN, 1'b1, "wd_sticky");
`ifdef STALL_PERF_EN
        @(negedge clk);
        #2;
        check("perf_frz", perf_frz, CNT_W'(n_frz));
        check("perf_haz", perf_haz, CNT_W'(n_haz));
        check("perf_flush", perf_flush, CNT_W'(n_fl));
`endif
        // reset mid-transaction clears timeout and outstanding state
        step(1'b1, 6'b001000, P_FRZ, 1'b1, "pre_rst_req");
        step(1'b0, 6'b000000, P_FRZ, 1'b0, "rst_clear");
        step(1'b1, 6'b000000, P_RUN, 1'b0, "post_rst_run");
`ifdef STALL_PERF_EN
        check("perf_frz_rst", perf_frz, {CNT_W{1'b0}});
`endif
        check("sb_empty", CNT_W'(sb_q.size()), {CNT_W{1'b0}});
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
